// File: rtl/seq_pkg.sv
// Shared opcode constants, state encoding and strobe bundle for control_sequencer.
package seq_pkg;

   // Primary opcodes, instruction bits [15:11]
   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_LHI  = 5'b00001;
   localparam logic [4:0] OP_LLI  = 5'b00010;
   localparam logic [4:0] OP_LDR  = 5'b00011;
   localparam logic [4:0] OP_STR  = 5'b00101;
   localparam logic [4:0] OP_ADDI = 5'b00111;
   localparam logic [4:0] OP_SUBI = 5'b01000;
   localparam logic [4:0] OP_JMP  = 5'b10000;
   localparam logic [4:0] OP_JAL1 = 5'b10001;
   localparam logic [4:0] OP_JAL2 = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_SYS  = 5'b11100;
   // Conditional branches match on bits [15:12] only
   localparam logic [3:0] OP_BR4  = 4'b1100;

   // ALU funct, instruction bits [1:0]
   localparam logic [1:0] FN_ADD = 2'b00;
   localparam logic [1:0] FN_ADC = 2'b01;
   localparam logic [1:0] FN_SUB = 2'b10;
   localparam logic [1:0] FN_SBB = 2'b11;

   // SYS funct, instruction bits [1:0]
   localparam logic [1:0] SYS_OUT = 2'b00;
   localparam logic [1:0] SYS_HLT = 2'b01;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_CLEAR,
      ST_RUN,
      ST_HALT
   } seq_state_t;

   // Field order matches the top-level strobe port order
   typedef struct packed {
      logic flag_HLT;
      logic data_write_en;
      logic flag_label_PC;
      logic flag_Rm_PC;
      logic flag_Rd_PC;
      logic BRANCH;
      logic ADC;
      logic SUB;
      logic SBB;
      logic JMP;
      logic Src_ALU_B;
      logic Src_Read_B;
      logic flag_mem_RF;
      logic flag_ALU_RF;
      logic flag_Rm_RF;
      logic flag_PC_RF;
      logic LHI;
      logic LLI;
      logic RF_write_en;
      logic flag_OutR;
   } strobe_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: fetched instruction -> datapath strobes.
module instr_decoder
   import seq_pkg::*;
(
   input  logic [15:0] mem_instr_out,
   output strobe_t     strobes,
   output logic        illegal_op
);

   logic [4:0] op;
   logic [1:0] funct;
   logic       unused_mid;

   assign op         = mem_instr_out[15:11];
   assign funct      = mem_instr_out[1:0];
   assign unused_mid = ^mem_instr_out[10:2];

   // Decode opcode/funct; flag_HLT stays high (PC advances) for everything but HLT
   always_comb begin
      strobes          = '0;
      strobes.flag_HLT = 1'b1;
      illegal_op       = 1'b0;
      if (op[4:1] == OP_BR4) begin
         strobes.BRANCH = 1'b1;
      end else begin
         case (op)
            OP_ALU: begin
               strobes.flag_ALU_RF = 1'b1;
               strobes.RF_write_en = 1'b1;
               case (funct)
                  FN_ADC:  strobes.ADC = 1'b1;
                  FN_SUB:  strobes.SUB = 1'b1;
                  FN_SBB:  strobes.SBB = 1'b1;
                  default: ;
               endcase
            end
            OP_LHI: begin
               strobes.LHI         = 1'b1;
               strobes.Src_Read_B  = 1'b1;
               strobes.RF_write_en = 1'b1;
            end
            OP_LLI: begin
               strobes.LLI         = 1'b1;
               strobes.RF_write_en = 1'b1;
            end
            OP_LDR: begin
               strobes.Src_ALU_B   = 1'b1;
               strobes.flag_mem_RF = 1'b1;
               strobes.RF_write_en = 1'b1;
            end
            OP_STR: begin
               strobes.Src_ALU_B     = 1'b1;
               strobes.Src_Read_B    = 1'b1;
               strobes.data_write_en = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
               strobes.Src_ALU_B   = 1'b1;
               strobes.flag_ALU_RF = 1'b1;
               strobes.RF_write_en = 1'b1;
               strobes.SUB         = (op == OP_SUBI);
            end
            OP_JMP: begin
               strobes.JMP           = 1'b1;
               strobes.flag_label_PC = 1'b1;
            end
            OP_JAL1: begin
               strobes.BRANCH      = 1'b1;
               strobes.flag_PC_RF  = 1'b1;
               strobes.RF_write_en = 1'b1;
            end
            OP_JAL2: begin
               strobes.JMP         = 1'b1;
               strobes.flag_Rm_PC  = 1'b1;
               strobes.flag_PC_RF  = 1'b1;
               strobes.RF_write_en = 1'b1;
            end
            OP_JR: begin
               strobes.JMP        = 1'b1;
               strobes.flag_Rd_PC = 1'b1;
               strobes.Src_Read_B = 1'b1;
            end
            OP_SYS: begin
               case (funct)
                  SYS_OUT: strobes.flag_OutR = 1'b1;
                  SYS_HLT: strobes.flag_HLT  = 1'b0;
                  default: illegal_op        = 1'b1;
               endcase
            end
            default: illegal_op = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: loads program/data memories, clears and runs the datapath,
// captures OUT results and stops on HLT.
// Optional build macro SEQ_SINGLE_STEP_EN adds a 'step' input gating execution.
module control_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned CLR_CYCLES = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             clr,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic             step,
`endif
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic             ld_target,
   input  logic [15:0]      ld_addr,
   input  logic [15:0]      ld_data,
   input  logic             ld_done,
   input  logic [15:0]      mem_instr_out,
   input  logic [15:0]      OutR,
   output logic             test_normal,
   output logic             ext_instr_we,
   output logic             ext_data_write_en,
   output logic [15:0]      ext_instr_addr,
   output logic [15:0]      ext_instr_data,
   output logic [15:0]      ext_data_addr,
   output logic [15:0]      ext_data_data,
   output logic             dp_clr,
   output logic             flag_HLT,
   output logic             data_write_en,
   output logic             flag_label_PC,
   output logic             flag_Rm_PC,
   output logic             flag_Rd_PC,
   output logic             BRANCH,
   output logic             ADC,
   output logic             SUB,
   output logic             SBB,
   output logic             JMP,
   output logic             Src_ALU_B,
   output logic             Src_Read_B,
   output logic             flag_mem_RF,
   output logic             flag_ALU_RF,
   output logic             flag_Rm_RF,
   output logic             flag_PC_RF,
   output logic             LHI,
   output logic             LLI,
   output logic             RF_write_en,
   output logic             flag_OutR,
   output logic             out_valid,
   output logic [15:0]      out_data,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   localparam int unsigned     CC_W     = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam logic [CC_W-1:0] CLR_LAST = CC_W'(CLR_CYCLES - 1);

   seq_state_t      state, state_nxt;
   logic [CC_W-1:0] clr_cnt;
   strobe_t         dec_st, st;
   logic            dec_illegal;
   logic            exec;
   logic            ld_accept;
   logic            out_pend;
   logic [15:0]     out_hold;

   instr_decoder u_dec (
      .mem_instr_out (mem_instr_out),
      .strobes       (dec_st),
      .illegal_op    (dec_illegal)
   );

`ifdef SEQ_SINGLE_STEP_EN
   assign exec = (state == ST_RUN) && step;
`else
   assign exec = (state == ST_RUN);
`endif

   // Non-executing cycles present a NOP with flag_HLT low so the PC holds
   assign st = exec ? dec_st : '0;
   assign {flag_HLT, data_write_en, flag_label_PC, flag_Rm_PC, flag_Rd_PC,
           BRANCH, ADC, SUB, SBB, JMP, Src_ALU_B, Src_Read_B, flag_mem_RF,
           flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI, RF_write_en,
           flag_OutR} = st;

   assign ld_ready    = (state == ST_LOAD) || (state == ST_HALT);
   assign ld_accept   = ld_valid && ld_ready;
   assign test_normal = (state == ST_LOAD);
   assign dp_clr      = (state == ST_CLEAR);
   assign halted      = (state == ST_HALT);
   assign out_valid   = out_pend;
   // OutR is written by the datapath at the end of the OUT cycle, so the fresh
   // value is passed through during the valid cycle and held afterwards
   assign out_data    = out_pend ? OutR : out_hold;

   // State register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= ST_LOAD;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD:  if (ld_done) state_nxt = ST_CLEAR;
         ST_CLEAR: if (clr_cnt == CLR_LAST) state_nxt = ST_RUN;
         ST_RUN:   if (exec && !dec_st.flag_HLT) state_nxt = ST_HALT;
         ST_HALT:  if (ld_valid) state_nxt = ST_LOAD;
         default:  state_nxt = ST_LOAD;
      endcase
   end

   // Counts cycles spent holding the datapath in clear
   always_ff @(posedge clk or posedge clr) begin
      if (clr)                    clr_cnt <= '0;
      else if (state == ST_CLEAR) clr_cnt <= clr_cnt + CC_W'(1);
      else                        clr_cnt <= '0;
   end

   // Registers an accepted load beat onto the datapath write ports for one cycle
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         ext_instr_we      <= 1'b0;
         ext_data_write_en <= 1'b0;
         ext_instr_addr    <= '0;
         ext_instr_data    <= '0;
         ext_data_addr     <= '0;
         ext_data_data     <= '0;
      end else begin
         ext_instr_we      <= ld_accept && !ld_target;
         ext_data_write_en <= ld_accept && ld_target;
         if (ld_accept && !ld_target) begin
            ext_instr_addr <= ld_addr;
            ext_instr_data <= ld_data;
         end
         if (ld_accept && ld_target) begin
            ext_data_addr <= ld_addr;
            ext_data_data <= ld_data;
         end
      end
   end

   // Retired counter, sticky illegal flag and OUT capture
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         retired  <= '0;
         illegal  <= 1'b0;
         out_pend <= 1'b0;
         out_hold <= '0;
      end else begin
         if (state == ST_CLEAR && state_nxt == ST_RUN)
            retired <= '0;
         else if (exec && retired != '1)
            retired <= retired + CNT_W'(1);
         illegal  <= illegal || (exec && dec_illegal);
         out_pend <= exec && dec_st.flag_OutR;
         if (out_pend) out_hold <= OutR;
      end
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Sits opposite Datapath_Module. It consumes the datapath's fetched instruction (mem_instr_out) and drives every datapath control strobe.
- It also owns the memory-load path: it accepts a host word stream and drives the ext_* instruction/data write ports. After loading, it pulses the datapath clear, runs the program, captures OutR results and stops on HLT.
- This replaces hand-driven control sequencing.

Parameters:
- CLR_CYCLES, 2, number of cycles dp_clr is held high between load completion and run.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- clr  in  1  reset; asynchronous, active-high
- ld_valid  in  1  host load beat valid
- ld_ready  out  1  sequencer accepts beat
- ld_target  in  1  0 = instruction memory, 1 = data memory
- ld_addr  in  16  target address
- ld_data  in  16  target word
- ld_done  in  1  pulse: loading finished, start program
- mem_instr_out  in  16  current instruction from datapath
- OutR  in  16  datapath output register
- test_normal, ext_instr_we, ext_data_write_en  out  1  datapath load controls
- ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data  out  16  datapath load bus
- dp_clr  out  1  datapath clear
- flag_HLT, data_write_en, flag_label_PC, flag_Rm_PC, flag_Rd_PC, BRANCH, ADC, SUB, SBB, JMP, Src_ALU_B, Src_Read_B, flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI, RF_write_en, flag_OutR  out  1  datapath control strobes
- out_valid  out  1  one-cycle pulse, out_data valid
- out_data  out  16  captured OutR
- halted  out  1  program reached HLT
- illegal  out  1  sticky: undecodable opcode seen
- retired  out  CNT_W  instructions executed since run start

Behaviour:
- States: LOAD, CLEAR, RUN, HALT.
- Reset: state = LOAD; test_normal = 1; all strobes 0 except flag_HLT = 0; ext_* = 0; dp_clr = 0; out_valid = 0; out_data = 0; halted = 0; illegal = 0; retired = 0.
- LOAD:
  - ld_ready = 1.
  - A beat with ld_valid is registered onto ext_* next cycle: we high for exactly one cycle, addr/data held.
  - ld_done in the same cycle as ld_valid: the beat is written first, then the transition occurs.
  - ld_done -> CLEAR.
- CLEAR:
  - test_normal = 0; dp_clr = 1 for CLR_CYCLES cycles; ld_ready = 0.
  - Then -> RUN; retired reset to 0.
- RUN:
  - Controls decoded combinationally from mem_instr_out; flag_HLT = 1 except on HLT.
  - retired increments every cycle, saturating at all-ones.
- Decode (op = [15:11]; unlisted strobes 0):
  - 00000 ALU, funct [1:0] 00/01/10/11 = ADD/ADC/SUB/SBB: flag_ALU_RF, RF_write_en, plus ADC/SUB/SBB per funct.
  - 00001 LHI: LHI, Src_Read_B, RF_write_en.
  - 00010 LLI: LLI, RF_write_en.
  - 00011 LDR: Src_ALU_B, flag_mem_RF, RF_write_en.
  - 00101 STR: Src_ALU_B, Src_Read_B, data_write_en.
  - 00111 ADDI: Src_ALU_B, flag_ALU_RF, RF_write_en.
  - 01000 SUBI: as ADDI plus SUB.
  - 10000 JMP: JMP, flag_label_PC.
  - 10001 JAL1: BRANCH, flag_PC_RF, RF_write_en.
  - 10010 JAL2: JMP, flag_Rm_PC, flag_PC_RF, RF_write_en.
  - 10011 JR: JMP, flag_Rd_PC, Src_Read_B.
  - [15:12] = 1100 BRANCH: BRANCH.
  - 11100 funct 00 OUT: flag_OutR. 11100 funct 01 HLT: flag_HLT = 0.
  - Anything else: NOP; illegal set sticky.
- OUT capture: the cycle after an OUT executes, out_data <= OutR and out_valid = 1 for one cycle. Back-to-back OUTs produce back-to-back pulses.
- HLT:
  - Executed HLT -> HALT: halted = 1; all strobes 0; flag_HLT = 0; retired frozen. HLT does count as retired.
  - From HALT, ld_valid -> LOAD (test_normal = 1, halted = 0); the beat is accepted.
- clr asserted mid-load or mid-run: immediate return to reset values. Partial memory contents are left as written.

Optional Feature:
- SEQ_SINGLE_STEP_EN: adds input step (1 bit).
- With the macro defined, RUN executes only in cycles where step = 1. Other cycles are forced to NOP with flag_HLT = 0 (PC stalled), retired is not incremented and there is no OUT capture.
- Without the macro, step is absent and RUN executes every cycle.

Decomposition:
- Package seq_pkg: opcode constants (OP_ALU, OP_LHI, OP_LLI, OP_LDR, OP_STR, OP_ADDI, OP_SUBI, OP_JMP, OP_JAL1, OP_JAL2, OP_JR, OP_BR4, OP_SYS), SYS funct constants, state encoding.
- One sub-module, instr_decoder: purely combinational, mem_instr_out -> strobes + illegal_op. The top holds the FSM, load registers, counter and capture.

Test Plan:
- Load instr words 0x1900@0 and 0xE001@1, plus data 0x0012@0, then ld_done -> ext_instr_we pulses twice with correct addr/data, ext_data_write_en pulses once, dp_clr high 2 cycles. In RUN, LDR strobes are asserted, then HLT drives flag_HLT = 0, halted = 1, retired = 2.
- mem_instr_out = 0x0346 (SUB) -> SUB = 1, flag_ALU_RF = 1, RF_write_en = 1, all other strobes 0.
- OUT instruction 0xE040 with OutR = 0x1234 -> flag_OutR = 1; the next cycle gives out_valid = 1, out_data = 0x1234.
- Opcode 0x7800 -> all strobes 0, illegal = 1 and it stays 1 after subsequent legal instructions.
- clr asserted during CLEAR -> state LOAD, dp_clr = 0, test_normal = 1 on the same cycle (asynchronous).
- SEQ_SINGLE_STEP_EN build: step low 5 cycles -> retired unchanged, flag_HLT = 0. A single step pulse -> retired +1.
